// File: rtl/posit_extraction_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : posit_extraction_pipe                                    |
// | Description : Multi-lane posit field extractor for the PPU front end.  |
// |               Decodes sign, regime k, exponent, mantissa, NaR and zero  |
// |               per lane, carries the result through an elastic           |
// |               valid/ready pipeline and keeps saturating NaR/zero        |
// |               operand counters.                                         |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+

// Supported posit formats; kept at compilation-unit scope so the block
// stays a single self-contained file.
typedef enum logic [1:0] {
    POSIT8_ES2  = 2'd0,
    POSIT16_ES1 = 2'd1,
    POSIT16_ES2 = 2'd2,
    POSIT32_ES2 = 2'd3
} posit_format_e;

function automatic int posit_width(input posit_format_e f);
    case (f)
        POSIT16_ES1, POSIT16_ES2: return 16;
        POSIT32_ES2:              return 32;
        default:                  return 8;
    endcase
endfunction

function automatic int exp_bits(input posit_format_e f);
    case (f)
        POSIT16_ES1: return 1;
        default:     return 2;
    endcase
endfunction

module posit_extraction_pipe #(
    parameter posit_format_e pFormat = posit_format_e'(0),
    parameter int LANES  = 1,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16,
    localparam int c_N   = posit_width(pFormat),
    localparam int c_ES  = exp_bits(pFormat),
    localparam int c_RS  = $clog2(c_N),
    localparam int c_KW  = c_RS + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cnt_clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*c_N-1:0]     In,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         Sign,
    output logic [LANES*c_KW-1:0]    k,
    output logic [LANES*c_ES-1:0]    Exponent,
    output logic [LANES*c_N-1:0]     Mantissa,
    output logic [LANES-1:0]         NaR,
    output logic [LANES-1:0]         zero,
    output logic [CNT_W-1:0]         nar_cnt,
    output logic [CNT_W-1:0]         zero_cnt
);

    // Per-lane packed record: {sign, k, exponent, mantissa, nar, zero}
    localparam int c_LW     = c_KW + c_ES + c_N + 3;
    localparam int c_PW     = LANES * c_LW;
    localparam int c_OFF_M  = 2;
    localparam int c_OFF_E  = c_OFF_M + c_N;
    localparam int c_OFF_K  = c_OFF_E + c_ES;

    // Field extraction for one posit; result uses the lane record layout.
    function automatic logic [c_LW-1:0] decode_lane(input logic [c_N-1:0] p);
        logic              sgn;
        logic              is_zero;
        logic              is_nar;
        logic [c_N-2:0]    r;
        logic [c_N-2:0]    s;
        logic              run_bit;
        logic              done;
        int                m;
        logic [c_KW-1:0]   kv;
        logic [c_ES-1:0]   ev;
        logic [c_N-1:0]    mv;
        is_zero = (p == '0);
        is_nar  = (p == {1'b1, {(c_N-1){1'b0}}});
        sgn     = p[c_N-1];
        // Negative posits are decoded from their two's complement magnitude
        r       = sgn ? -p[c_N-2:0] : p[c_N-2:0];
        run_bit = r[c_N-2];
        m       = 0;
        done    = 1'b0;
        for (int i = c_N - 2; i >= 0; i--) begin
            if (!done && (r[i] == run_bit)) begin
                m = m + 1;
            end else begin
                done = 1'b1;
            end
        end
        kv = run_bit ? c_KW'(m - 1) : c_KW'(-m);
        // Drop regime run and its terminator; missing bits read as zero
        s  = r << (m + 1);
        ev = s[c_N-2 -: c_ES];
        mv = {1'b1, s[c_N-c_ES-2:0], {c_ES{1'b0}}};
        if (is_zero || is_nar) begin
            kv = '0;
            ev = '0;
            mv = '0;
        end
        return {sgn, kv, ev, mv, is_nar, is_zero};
    endfunction

    logic [c_PW-1:0]   w_dec;
    logic [LANES-1:0]  w_lane_nar;
    logic [LANES-1:0]  w_lane_zero;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_dec[l*c_LW +: c_LW] = decode_lane(In[l*c_N +: c_N]);
            assign w_lane_nar[l]         = w_dec[l*c_LW + 1];
            assign w_lane_zero[l]        = w_dec[l*c_LW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [c_PW-1:0]   data_q [STAGES];
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_vin;
    logic [c_PW-1:0]   w_din [STAGES];
    logic [c_PW-1:0]   w_out;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            // A stage can load unless it and every stage after it are full
            // while the consumer stalls; flattened to avoid a ready chain.
            assign w_load[s] = out_ready | ~(&valid_q[STAGES-1:s]);
            if (s == 0) begin : g_first
                assign w_vin[s] = in_valid;
                assign w_din[s] = w_dec;
            end else begin : g_next
                assign w_vin[s] = valid_q[s-1];
                assign w_din[s] = data_q[s-1];
            end
        end
    endgenerate

    // Advance each stage when it is free or its content is being taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_load[s]) begin
                    valid_q[s] <= w_vin[s];
                    if (w_vin[s]) begin
                        data_q[s] <= w_din[s];
                    end
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = valid_q[STAGES-1];
    assign w_out     = data_q[STAGES-1];

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_out_lane
            assign Sign[l]                   = w_out[l*c_LW + c_LW - 1];
            assign k[l*c_KW +: c_KW]         = w_out[l*c_LW + c_OFF_K +: c_KW];
            assign Exponent[l*c_ES +: c_ES]  = w_out[l*c_LW + c_OFF_E +: c_ES];
            assign Mantissa[l*c_N +: c_N]    = w_out[l*c_LW + c_OFF_M +: c_N];
            assign NaR[l]                    = w_out[l*c_LW + 1];
            assign zero[l]                   = w_out[l*c_LW];
        end
    endgenerate

    // ------------------------------------------------------------------
    // NaR / zero event counters
    // ------------------------------------------------------------------
    logic               w_xfer;
    logic [3:0]         w_nar_pop;
    logic [3:0]         w_zero_pop;
    logic [CNT_W+3:0]   w_nar_sum;
    logic [CNT_W+3:0]   w_zero_sum;
    logic [CNT_W-1:0]   nar_cnt_q;
    logic [CNT_W-1:0]   nar_cnt_d;
    logic [CNT_W-1:0]   zero_cnt_q;
    logic [CNT_W-1:0]   zero_cnt_d;

    assign w_xfer = in_valid & w_load[0];

    // Count flagged lanes of the beat presented at the input
    always_comb begin
        w_nar_pop  = '0;
        w_zero_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            w_nar_pop  = w_nar_pop  + {3'b000, w_lane_nar[l]};
            w_zero_pop = w_zero_pop + {3'b000, w_lane_zero[l]};
        end
    end

    assign w_nar_sum  = {4'b0000, nar_cnt_q}  + {{CNT_W{1'b0}}, w_nar_pop};
    assign w_zero_sum = {4'b0000, zero_cnt_q} + {{CNT_W{1'b0}}, w_zero_pop};
    assign nar_cnt_d  = (w_nar_sum[CNT_W+3:CNT_W] != 4'b0000)  ? {CNT_W{1'b1}} : w_nar_sum[CNT_W-1:0];
    assign zero_cnt_d = (w_zero_sum[CNT_W+3:CNT_W] != 4'b0000) ? {CNT_W{1'b1}} : w_zero_sum[CNT_W-1:0];

    // Saturating accumulate on accepted beats; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nar_cnt_q  <= '0;
            zero_cnt_q <= '0;
        end else if (cnt_clr) begin
            nar_cnt_q  <= '0;
            zero_cnt_q <= '0;
        end else if (w_xfer) begin
            nar_cnt_q  <= nar_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign nar_cnt  = nar_cnt_q;
    assign zero_cnt = zero_cnt_q;

endmodule
`default_nettype wire
